// File: rtl/shifter_pipe_flags.sv
// Pipelined barrel shifter/rotator with run-time mode, carry/zero/illegal-mode flags
// and valid/ready handshakes on both sides.
module shifter_pipe_flags #(
  parameter int  DATA_WIDTH     = 32,
  parameter int  STAGES_PER_REG = 1,
  parameter int  TAG_WIDTH      = 4,
  localparam int AMT_WIDTH      = $clog2(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [AMT_WIDTH-1:0]  shiftAmount,
  input  logic [2:0]            mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero,
  output logic                  mode_err,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_ROL = 3'd1;
  localparam logic [2:0] MODE_LSR = 3'd2;
  localparam logic [2:0] MODE_ASR = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [AMT_WIDTH-1:0]  amt;
    logic [2:0]            mode;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  valid;
    logic                  cand;
  } stage_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // Every stage advances together on adv; when adv=0 all stages hold their contents.
  logic   adv;
  stage_t in_bus;
  stage_t stg_out [AMT_WIDTH];
  stage_t fin;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  carry_q;
  logic                  mode_err_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  carry_d;
  logic                  mode_err_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv || !reset;

  assign in_bus = '{data: dataA, amt: shiftAmount, mode: mode, tag: in_tag,
                    valid: in_valid, cand: 1'b0};

  for (genvar k = 0; k < AMT_WIDTH; k++) begin : g_stage
    localparam int DIST    = 1 << k;
    localparam bit HAS_REG = (((k + 1) % STAGES_PER_REG) == 0) && (k != AMT_WIDTH - 1);

    stage_t s_in;
    stage_t s_sh;

    if (k == 0) begin : g_head
      assign s_in = in_bus;
    end else begin : g_tail
      assign s_in = stg_out[k-1];
    end

    // cand tracks the last bit pushed out by a plain shift; rotates resolve carry at the end.
    always_comb begin
      s_sh = s_in;
      if (s_in.amt[k]) begin
        case (s_in.mode)
          MODE_LSL: begin
            s_sh.data = s_in.data << DIST;
            s_sh.cand = s_in.data[DATA_WIDTH-DIST];
          end
          MODE_LSR: begin
            s_sh.data = s_in.data >> DIST;
            s_sh.cand = s_in.data[DIST-1];
          end
          MODE_ASR: begin
            s_sh.data = $signed(s_in.data) >>> DIST;
            s_sh.cand = s_in.data[DIST-1];
          end
          MODE_ROL: s_sh.data = (s_in.data << DIST) | (s_in.data >> (DATA_WIDTH - DIST));
          MODE_ROR: s_sh.data = (s_in.data >> DIST) | (s_in.data << (DATA_WIDTH - DIST));
          default:  s_sh.data = s_in.data;
        endcase
      end
    end

    if (HAS_REG) begin : g_reg
      stage_t s_q;
      always_ff @(posedge clock) begin
        if (!reset) begin
          s_q.valid <= 1'b0;
        end else if (adv) begin
          s_q <= s_sh;
        end
      end
      assign stg_out[k] = s_q;
    end else begin : g_wire
      assign stg_out[k] = s_sh;
    end
  end

  assign fin = stg_out[AMT_WIDTH-1];

  always_comb begin
    carry_d    = fin.cand;
    mode_err_d = (fin.mode > MODE_ROR);
    if (fin.mode == MODE_ROL) begin
      carry_d = (|fin.amt) & fin.data[0];
    end else if (fin.mode == MODE_ROR) begin
      carry_d = (|fin.amt) & fin.data[DATA_WIDTH-1];
    end
  end

  // Payload only loads with a valid operation so presented values persist across bubbles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      mode_err_q  <= 1'b0;
      tag_q       <= '0;
    end else if (adv) begin
      out_valid_q <= fin.valid;
      if (fin.valid) begin
        result_q   <= fin.data;
        carry_q    <= carry_d;
        mode_err_q <= mode_err_d;
        tag_q      <= fin.tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = (result_q == '0);
  assign mode_err  = mode_err_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_shifter_pipe_flags.sv
// Bench for shifter_pipe_flags: directed vector table, backpressure, mid-stream reset,
// randomized traffic against an arithmetic reference model, and a 16-bit / 2-stage-per-reg instance.
module tb_shifter_pipe_flags;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dataA;
  logic [4:0]  shiftAmount;
  logic [2:0]  mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        mode_err;
  logic [3:0]  out_tag;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_dataA;
  logic [3:0]  s_amt;
  logic [2:0]  s_mode;
  logic [3:0]  s_tag;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_result;
  logic        s_carry;
  logic        s_zero;
  logic        s_err;
  logic [3:0]  s_out_tag;

  int total = 0;
  int bad   = 0;
  int cons_cnt = 0;
  logic sb_on = 1'b0;
  logic [38:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [39:0] prev_snap;

  shifter_pipe_flags #(.DATA_WIDTH(32), .STAGES_PER_REG(1), .TAG_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .shiftAmount(shiftAmount), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .zero(zero), .mode_err(mode_err), .out_tag(out_tag)
  );

  shifter_pipe_flags #(.DATA_WIDTH(16), .STAGES_PER_REG(2), .TAG_WIDTH(4)) dut16 (
    .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dataA(s_dataA), .shiftAmount(s_amt), .mode(s_mode), .in_tag(s_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .carry(s_carry),
    .zero(s_zero), .mode_err(s_err), .out_tag(s_out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        e;
  } ref_t;

  // Reference: whole-operation arithmetic on a w-bit value.
  function automatic ref_t model(input int w, input logic [2:0] m, input logic [63:0] a_in,
                                 input int amt);
    ref_t r;
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] res;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    r.c  = 1'b0;
    r.e  = 1'b0;
    case (m)
      3'd0: begin res = (a << amt) & mask; if (amt != 0) r.c = a[w-amt]; end
      3'd2: begin res = a >> amt; if (amt != 0) r.c = a[amt-1]; end
      3'd3: begin
        res = (a >> amt) | (a[w-1] ? (mask & ~(mask >> amt)) : 64'd0);
        if (amt != 0) r.c = a[amt-1];
      end
      3'd1: begin
        res = (amt == 0) ? a : (((a << amt) | (a >> (w - amt))) & mask);
        if (amt != 0) r.c = res[0];
      end
      3'd4: begin
        res = (amt == 0) ? a : (((a >> amt) | (a << (w - amt))) & mask);
        if (amt != 0) r.c = res[w-1];
      end
      default: begin res = a; r.e = 1'b1; end
    endcase
    r.res = res;
    r.z   = (res == 64'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pushes model results on accept, pops and compares on consume, checks stall hold.
  always @(negedge clock) begin
    ref_t r;
    logic [38:0] e;
    if (!reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {24'd0, out_valid, result, carry, zero, mode_err, out_tag}, {24'd0, prev_snap});
      if (sb_on && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got output tag %0h result %0h want none", out_tag, result);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", {25'd0, result, carry, zero, mode_err, out_tag}, {25'd0, e});
          cons_cnt++;
        end
      end
      if (sb_on && in_valid && in_ready) begin
        r = model(32, mode, {32'd0, dataA}, int'(shiftAmount));
        exp_q.push_back({r.res[31:0], r.c, r.z, r.e, in_tag});
      end
      prev_stall = out_valid && !out_ready;
      prev_snap  = {out_valid, result, carry, zero, mode_err, out_tag};
    end
  end

  task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [4:0] amt,
                       input logic [3:0] tg);
    logic ok;
    @(posedge clock); #1;
    in_valid = 1'b1; mode = m; dataA = a; shiftAmount = amt; in_tag = tg;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
    end
    check("issue_accept", {63'd0, ok}, 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (out_valid) begin n = i; break; end
    end
  endtask

  task automatic stream(input int cnt);
    logic ok;
    @(posedge clock); #1;
    for (int t = 0; t < cnt; t++) begin
      in_valid = 1'b1; in_tag = t[3:0]; dataA = $urandom;
      shiftAmount = 5'($urandom_range(0, 31)); mode = 3'($urandom_range(0, 4));
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clock);
        if (in_ready) ok = 1'b1;
      end
      check("stream_accept", {63'd0, ok}, 64'd1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        e;
  } vec_t;

  typedef struct {
    logic [2:0]  m;
    logic [15:0] a;
    logic [3:0]  amt;
    logic [15:0] res;
    logic        c;
  } vec16_t;

  vec_t   tbl[7];
  vec16_t tbl16[3];

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; dataA = '0; shiftAmount = '0;
    mode = '0; in_tag = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_dataA = '0; s_amt = '0; s_mode = '0; s_tag = '0;

    tbl[0] = '{3'd0, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'd3, 32'h800000F0, 5'd4,  32'hF800000F, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{3'd4, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{3'd1, 32'h12345678, 5'd8,  32'h34567812, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'd0, 32'h80000000, 5'd1,  32'h00000000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{3'd6, 32'hDEADBEEF, 5'd3,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    tbl16[0] = '{3'd4, 16'h0001, 4'd15, 16'h0002, 1'b0};
    tbl16[1] = '{3'd0, 16'h8001, 4'd1,  16'h0002, 1'b1};
    tbl16[2] = '{3'd3, 16'h8000, 4'd15, 16'hFFFF, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in_ready_in_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags", {60'd0, carry, zero, mode_err, out_valid}, {60'd0, 4'b0100});
    check("rst_tag", {60'd0, out_tag}, 64'd0);

    // Directed table, one operation at a time.
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].m, tbl[i].a, tbl[i].amt, 4'(i));
      wait_out(n);
      check($sformatf("v%0d_latency", i), 64'(n), 64'd5);
      check($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, tbl[i].res});
      check($sformatf("v%0d_carry", i), {63'd0, carry}, {63'd0, tbl[i].c});
      check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, tbl[i].z});
      check($sformatf("v%0d_err", i), {63'd0, mode_err}, {63'd0, tbl[i].e});
      check($sformatf("v%0d_tag", i), {60'd0, out_tag}, 64'(i));
    end
    repeat (3) @(posedge clock);

    // Backpressure: 8 back-to-back ops, 3-cycle consumer stall after the first output.
    sb_on = 1'b1;
    cons_cnt = 0;
    fork
      stream(8);
      begin
        logic seen;
        int gaps;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clock);
          if (out_valid) seen = 1'b1;
        end
        check("bp_first_out", {63'd0, seen}, 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 40 && cons_cnt < 8; i++) begin
          @(negedge clock);
          if (!out_valid) gaps++;
          #1;
        end
        check("bp_gaps", 64'(gaps), 64'd0);
        check("bp_count", 64'(cons_cnt), 64'd8);
      end
    join
    repeat (8) @(posedge clock);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three operations in flight; an op offered during reset is dropped.
    stream(3);
    reset = 1'b0;
    in_valid = 1'b1; dataA = 32'h00FF00FF; shiftAmount = 5'd4; mode = 3'd0; in_tag = 4'hA;
    @(negedge clock);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_result", {32'd0, result}, 64'd0);
    check("mid_rst_zero", {63'd0, zero}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("mid_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    issue(3'd2, 32'hF0000000, 5'd4, 4'h5);
    wait_out(n);
    check("post_rst_latency", 64'(n), 64'd5);
    check("post_rst_result", {32'd0, result}, 64'h0F000000);
    repeat (3) @(posedge clock);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      in_valid    = ($urandom_range(0, 3) != 0);
      dataA       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      shiftAmount = 5'($urandom_range(0, 31));
      mode        = 3'($urandom_range(0, 7));
      in_tag      = 4'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clock);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;

    // 16-bit instance, two tree stages per register.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      s_in_valid = 1'b1; s_mode = tbl16[i].m; s_dataA = tbl16[i].a; s_amt = tbl16[i].amt;
      s_tag = 4'(i);
      @(negedge clock);
      check($sformatf("w16_%0d_in_ready", i), {63'd0, s_in_ready}, 64'd1);
      @(posedge clock); #1;
      s_in_valid = 1'b0;
      n = 99;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clock);
        if (s_out_valid) begin n = j; break; end
      end
      check($sformatf("w16_%0d_latency", i), 64'(n), 64'd2);
      check($sformatf("w16_%0d_result", i), {48'd0, s_result}, {48'd0, tbl16[i].res});
      check($sformatf("w16_%0d_carry", i), {63'd0, s_carry}, {63'd0, tbl16[i].c});
      check($sformatf("w16_%0d_tag", i), {60'd0, s_out_tag}, 64'(i));
    end
    repeat (3) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_pipe_flags.md
Name: shifter_pipe_flags

Overview:
- Parametrised, pipelined successor to the combinational 32-bit fixed-mode shifter used in the arith library.
- Shift/rotate mode is selected per operation at run time, not by parameter.
- Width is generic, pipeline depth is configurable, and flag outputs are produced.
- Valid/ready handshakes on both sides so the execute stage can issue one shift per cycle and tolerate writeback backpressure.

Parameters:
- DATA_WIDTH, 32, operand width; power of two, 8..64; AMT_WIDTH = log2(DATA_WIDTH) is derived, not settable.
- STAGES_PER_REG, 1, binary-tree stages (shift by 2^k) per pipeline register, 1..AMT_WIDTH.
  - Latency L = ceil(AMT_WIDTH/STAGES_PER_REG).
- TAG_WIDTH, 4, width of the sideband tag carried alongside each operation (e.g. destination register).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- dataA  in  DATA_WIDTH  operand.
- shiftAmount  in  AMT_WIDTH  shift distance.
- mode  in  3  0 LSL, 1 ROL, 2 LSR, 3 ASR, 4 ROR, 5..7 illegal.
- in_tag  in  TAG_WIDTH  sideband, returned unchanged.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts.
- result  out  DATA_WIDTH  shifted value.
- carry  out  1  last bit shifted/rotated out (see Behaviour).
- zero  out  1  result == 0.
- mode_err  out  1  operation used an illegal mode.
- out_tag  out  TAG_WIDTH  tag of presented result.

Behaviour:
- Datapath: binary tree, stage k shifts by 2^k when shiftAmount[k]=1.
- Shift-in per stage:
  - LSL/LSR: zeros.
  - ASR: copies of the current MSB.
  - ROL/ROR: bits leaving the opposite end.
- Pipeline registers sit after stage k when (k+1) mod STAGES_PER_REG == 0, and always after the last stage.
- Each register holds data, the remaining amount bits, mode, tag, valid, and the carry candidate.
- Latency: operation accepted in cycle 0 (in_valid && in_ready at an edge) → out_valid=1 from cycle L.
  - Default config: L=5.
- Throughput: one operation per cycle while out_ready=1.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - When adv=0 every stage holds; nothing is overwritten or dropped.
  - Bubbles are not collapsed.
  - A stage with valid=0 still shifts but its contents are don't-care; out_valid depends only on the valid chain.
- Carry:
  - shiftAmount==0 → 0, all modes.
  - LSL: dataA[DATA_WIDTH-amt].
  - LSR/ASR: dataA[amt-1].
  - ROL: result[0].
  - ROR: result[DATA_WIDTH-1].
- zero is computed from the final result in the output cycle; it is combinational from the output register.
- Illegal mode 5..7: result=dataA unshifted, carry=0, mode_err=1, zero computed normally; no other side effect.
- While out_valid=0: result, carry, zero, mode_err and out_tag hold their last values and are don't-care to consumers.
- Reset (reset=0 at an edge):
  - All valid bits → 0; result, out_tag, carry, zero(=1), mode_err → 0.
  - in_ready reads 1 during and after reset, since out_valid=0.
  - Operations in flight mid-pipeline are discarded.
  - An operation offered in the reset cycle is not accepted.
- Simultaneous input accept and output consume in one cycle are both legal; the pipeline shifts by one.
- out_valid, result, carry, zero, mode_err and out_tag must not change while out_valid=1 and out_ready=0.

Test Plan:
- W=32, L=5:
  - LSL dataA=0x80000001 amt=1 → result 0x00000002, carry 1, zero 0, out_valid exactly 5 cycles after accept.
  - ASR 0x800000F0 amt=4 → 0xF800000F, carry 0.
  - LSR 0xFFFFFFFF amt=31 → 0x00000001, carry 1.
- ROR 0x00000001 amt=1 → 0x80000000, carry 1.
- ROL 0x12345678 amt=8 → 0x34567812, carry 0.
- LSL 0x80000000 amt=1 → 0x00000000, zero 1, carry 1.
- mode=6, dataA=0xDEADBEEF amt=3 → result 0xDEADBEEF, mode_err 1, carry 0.
- Backpressure: stream 8 ops with tags 0..7 back-to-back, hold out_ready=0 for 3 cycles after the first output.
  - Required: in_ready=0 during the stall, outputs stable.
  - All 8 results delivered in tag order with none lost or duplicated.
  - Then 1 result/cycle.
- Reset mid-stream: 3 ops in flight, reset=0 for one edge.
  - Required: out_valid=0 the next cycle; no stale result appears.
  - A new op accepted after reset is delivered 5 cycles later.
- Config DATA_WIDTH=16, STAGES_PER_REG=2 (L=2): ROR 0x0001 amt=15 → 0x0002, carry 0, latency 2 cycles.
